serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 24 ++
 rtl/full_subtractor.sv | 20 ++
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// +----------------------------------------------------------------------+
// | serial_sub_pkg : shared types and helpers for the serial subtractor  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 8;

  // Counter must be able to hold WIDTH itself without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// +----------------------------------------------------------------------+
// | full_subtractor : one-bit x - y - bin cell with borrow out            |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +----------------------------------------------------------------------+
// | serial_subtractor : bit-serial a - b, LSB first, one bit per clock    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             w_bit_d;
  logic             w_bit_bout;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] w_res_shift;

  full_subtractor u_fs (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (br_q),
    .d    (w_bit_d),
    .bout (w_bit_bout)
  );

  assign w_load      = start && ((state_q == IDLE) || (state_q == DONE));
  assign w_last      = (state_q == RUN) && (cnt_q == CNT_LAST);
  assign w_res_shift = {w_bit_d, res_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (w_last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_comb begin
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    if (w_load) begin
      a_sh_d = a;
      b_sh_d = b;
      res_d  = '0;
      cnt_d  = '0;
      br_d   = 1'b0;
    end else if (state_q == RUN) begin
      a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
      res_d  = w_res_shift;
      cnt_d  = cnt_q + CNT_W'(1);
      br_d   = w_bit_bout;
      if (w_last) begin
        diff_d   = w_res_shift;
        borrow_d = w_bit_bout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// +----------------------------------------------------------------------+
// | tb_serial_subtractor : randomized scoreboard bench for the subtractor |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    int           k;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_chk = 0;
  int           n_fail = 0;
  int           la = -1000;
  int           next_ok = 0;
  logic [W-1:0] held_d = '0;
  logic         held_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("busy", 32'(busy), 32'(cyc >= la && cyc <= la + W - 1));
      check("done", 32'(done), 32'(cyc == la + W));
      check("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("diff", 32'(diff), 32'(mon_e.d));
          check("borrow", 32'(borrow), 32'(mon_e.br));
          check("latency", 32'(cyc - mon_e.k), 32'(W));
          held_d = mon_e.d;
          held_b = mon_e.br;
        end
      end else begin
        check("diff_held", 32'(diff), 32'(held_d));
        check("borrow_held", 32'(borrow), 32'(held_b));
      end
    end
  end

  // Drive one cycle; predict acceptance from the model's own timeline.
  task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv, output bit acc);
    logic [W-1:0] r;
    @(posedge clk);
    #3;
    start = s;
    a     = av;
    b     = bv;
    acc   = 1'b0;
    if (s && (cyc + 1 >= next_ok)) begin
      acc     = 1'b1;
      la      = cyc + 1;
      next_ok = cyc + 1 + W + 1;
      r       = av - bv;
      sb.push_back('{d: r, br: (av < bv), k: cyc + 1});
    end
  endtask

  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv);
    bit acc;
    int g;
    g = 0;
    do begin
      drive(1'b1, av, bv, acc);
      g++;
    end while (!acc && g < 100);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) drive(1'b0, W'($urandom), W'($urandom), acc);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    start = 1'b0;
    rst   = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow), 32'd0);
    sb.delete();
    la     = -1000;
    held_d = '0;
    held_b = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst     = 1'b0;
    next_ok = cyc + 1;
  endtask

  logic [W-1:0] dir_a[5] = '{8'h5A, 8'h10, 8'h00, 8'hFF, 8'h00};
  logic [W-1:0] dir_b[5] = '{8'h23, 8'h20, 8'h00, 8'h01, 8'h01};

  initial begin
    bit acc;
    int g;
    #2;
    check("init_busy", 32'(busy), 32'd0);
    check("init_done", 32'(done), 32'd0);
    check("init_diff", 32'(diff), 32'd0);
    check("init_borrow", 32'(borrow), 32'd0);
    @(posedge clk);
    #3;
    rst     = 1'b0;
    next_ok = cyc + 1;

    for (int i = 0; i < 5; i++) begin
      op(dir_a[i], dir_b[i]);
      idle(W + 2);
    end

    // start during RUN must be ignored
    op(8'h80, 8'h01);
    idle(2);
    drive(1'b1, 8'h11, 8'h11, acc);
    check("ignored_start", 32'(acc), 32'd0);
    idle(W + 3);

    // back-to-back via DONE
    op(8'h09, 8'h04);
    while (cyc + 2 < next_ok) drive(1'b1, 8'h09, 8'h04, acc);
    op(8'h04, 8'h09);
    idle(W + 3);

    // reset during RUN aborts the operation
    op(8'hC3, 8'h5E);
    idle(3);
    do_reset();
    idle(W + 2);
    op(8'h33, 8'h11);
    idle(W + 2);

    repeat (30) begin
      op(W'($urandom), W'($urandom));
      idle($urandom_range(0, W + 3));
    end

    g = 0;
    while (sb.size() > 0 && g < 100) begin
      idle(1);
      g++;
    end
    if (sb.size() > 0) check("drain_timeout", 32'd0, 32'd1);
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
